seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Eight-digit, time-multiplexed 7-segment display driver sitting directly downstream of the free-running 20-bit scan prescaler; it consumes that prescaler's 3-bit digit index. It holds a double-buffered 32-bit hex value and swaps buffers only at frame boundaries, so the display never tears. It inserts a blanking interval on every digit change to suppress ghosting, and it optionally suppresses leading zeros. All display outputs are registered and active-low.

## Interface
- BLANK_CYCLES, 64: clk cycles all digits are dark after each index change; legal range 1 to (scan step period − 1).
- LZ_SUPPRESS, 1: 1 = blank leading zero digits (digit 0 always shown); 0 = show all digits.
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- scan_idx  in  3  digit index from the upstream prescaler; synchronous to clk; changes every 2^17 clk.
- data_in  in  32  hex value; digit k = data_in[4k+3:4k].
- dp_in  in  8  decimal points; bit k = digit k, 1 = lit.
- load  in  1  one-cycle strobe; captures data_in/dp_in into the shadow buffer.
- pending  out  1  shadow holds data not yet displayed.
- frame_start  out  1  one-cycle pulse at each 7→0 index transition.
- an  out  8  digit anodes, active-low, one-hot-low or all high.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

## Operation
- Reset (async, immediate): active and shadow buffers = 0, pending = 0, idx_q = 0, state = BLANK, blank counter = BLANK_CYCLES−1, an = 8'hFF, seg = 7'h7F, dp = 1, frame_start = 0.
- idx_q registers scan_idx every edge. An index change is detected as scan_idx ≠ idx_q.
- State machine:
  - BLANK: outputs dark (an = FF, seg = 7F, dp = 1). The counter decrements each edge. When the counter is 0, go to SHOW.
  - SHOW: an[idx_q] = 0, others 1. seg/dp are decoded from active nibble idx_q / dp bit idx_q.
  - Any index change, from either state: go to BLANK and reload counter = BLANK_CYCLES−1. A change during BLANK restarts the interval.
- Non-sequential index jumps are handled identically to sequential ones.
- Load: a load edge writes shadow ← {data_in, dp_in} and sets pending = 1. A load while pending overwrites the shadow (latest wins).
- Frame boundary: an index change with idx_q = 7 and scan_idx = 0.
  - frame_start pulses on every boundary.
  - If pending, active ← shadow (the pre-edge contents) and pending ← 0.
  - A simultaneous load and boundary: the swap takes the old shadow; the new load is captured into the shadow; pending stays 1.
- Hex decode, active-low gfedcba: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
- Leading-zero suppression (LZ_SUPPRESS = 1): digit k > 0 gets seg = 7F when active nibbles k..7 are all 0. Its anode and dp still follow normal rules.

## Timing
- E0 = first edge sampling a new scan_idx.
- Outputs go dark in the cycle after E0 and stay dark for exactly BLANK_CYCLES cycles. The new digit is driven from edge E0+BLANK_CYCLES onward.
- After reset release, digit 0 lights BLANK_CYCLES cycles after the first edge, given stable scan_idx.
- frame_start is high for the one cycle after the boundary E0. The new active data is visible on digit 0 after that boundary's blank interval.
- pending rises in the cycle after the load edge.
- pending falls in the cycle after the boundary edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset/first light:
  - Stimulus: rst_n low, then release with scan_idx = 0, BLANK_CYCLES = 4.
  - Response: an = FF, seg = 7F for 4 cycles, then an = FE, seg = 1000000.
- Blanking and restart:
  - Stimulus: step scan_idx 0→1, and again 1→2 two cycles later.
  - Response: dark for 2 + 4 cycles total, then an = FB.
- Double buffer:
  - Stimulus: load 32'h0000_00A5 mid-frame.
  - Response: pending = 1; display unchanged until 7→0. At the boundary, frame_start pulses once and pending → 0; digit 0 shows 5 (0010010), digit 1 shows A (0001000).
- Leading zeros:
  - Stimulus: active = 32'h0000_0100, LZ_SUPPRESS = 1.
  - Response: digits 3–7 seg = 7F; digits 0–2 show 0, 0, 1.
  - With LZ_SUPPRESS = 0: all eight digits show their values.
- Load collision:
  - Stimulus: load 0x11111111 and, later, load 0x22222222 on the same edge as the boundary.
  - Response: 1s displayed; pending stays 1; 2s displayed after the next boundary.
- Async reset mid-SHOW:
  - Stimulus: drop rst_n between clk edges.
  - Response: an = FF, seg = 7F, dp = 1 immediately; pending = 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
//
// seg7_scan_driver
// ----------------
// Eight-digit, time-multiplexed, active-low 7-segment display driver.
//
// The upstream scan prescaler supplies a 3-bit digit index (scan_idx) that
// steps slowly. This block lights one digit at a time, based on that index.
//
// Two 32-bit hex buffers are kept:
//   - The "active" buffer is what the display shows.
//   - The "shadow" buffer is written by the load strobe.
// The shadow is copied into the active buffer only at a frame boundary
// (index 7 -> 0). Because of this, a frame never mixes old and new digits.
//
// Every index change starts a blanking interval of BLANK_CYCLES clocks.
// During that interval all anodes are dark, so the previous digit's
// segments cannot ghost onto the new anode.
//
// Leading-zero suppression is optional. When it is on, a digit above
// digit 0 has its segments blanked if it and every higher digit are zero.
//
// Parameters
//   BLANK_CYCLES  dark clocks after each index change
//                 (1 .. scan step period - 1)
//   LZ_SUPPRESS   1 = blank leading zero digits, 0 = show all digits
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   scan_idx     digit index from the scan prescaler
//   data_in      hex value, digit k = data_in[4k+3:4k]
//   dp_in        decimal points, bit k = digit k, 1 = lit
//   load         one-cycle strobe capturing data_in/dp_in into the shadow
//   pending      shadow holds data not yet displayed
//   frame_start  one-cycle pulse after each 7 -> 0 index transition
//   an           digit anodes, active-low (one-hot-low or all high)
//   seg          segments {g,f,e,d,c,b,a}, active-low
//   dp           decimal point, active-low
//
module seg7_scan_driver #(
    parameter int BLANK_CYCLES = 64,
    parameter bit LZ_SUPPRESS  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  scan_idx,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic        load,
    output logic        pending,
    output logic        frame_start,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    // The counter only ever holds BLANK_CYCLES-1 down to 0.
    localparam int CW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(BLANK_CYCLES - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [2:0]      idx_q;

    logic [31:0]     active_data;
    logic [7:0]      active_dp;
    logic [31:0]     shadow_data;
    logic [7:0]      shadow_dp;

    logic            idx_change;
    logic            frame_edge;

    logic [7:0]      zero_from;
    logic [3:0]      cur_nibble;
    logic            lz_blank;

    logic [7:0]      an_d;
    logic [6:0]      seg_d;
    logic            dp_d;

    // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Any difference between the incoming index and the registered one
    // counts as a digit change. This covers sequential steps and arbitrary
    // jumps alike. Only the 7 -> 0 step marks a frame boundary.
    assign idx_change = (scan_idx != idx_q);
    assign frame_edge = idx_change && (idx_q == 3'd7) && (scan_idx == 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 3'd0;
        end else begin
            idx_q <= scan_idx;
        end
    end

    // Blank/show sequencing.
    // An index change always forces BLANK and restarts the interval, even
    // when the block is already blanking.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (idx_change) begin
            state_d = ST_BLANK;
            cnt_d   = CNT_RELOAD;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == '0) begin
                        state_d = ST_SHOW;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_SHOW: begin
                    state_d = ST_SHOW;
                end
                default: begin
                    state_d = ST_BLANK;
                    cnt_d   = CNT_RELOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
            cnt_q   <= CNT_RELOAD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Double buffer.
    // At a boundary the swap uses the shadow contents from before the edge.
    // A load on the same edge therefore lands in the shadow for the next
    // frame, and pending stays set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_data <= 32'd0;
            active_dp   <= 8'd0;
            shadow_data <= 32'd0;
            shadow_dp   <= 8'd0;
            pending     <= 1'b0;
        end else begin
            if (frame_edge && pending) begin
                active_data <= shadow_data;
                active_dp   <= shadow_dp;
            end
            if (load) begin
                shadow_data <= data_in;
                shadow_dp   <= dp_in;
            end
            if (load) begin
                pending <= 1'b1;
            end else if (frame_edge) begin
                pending <= 1'b0;
            end
        end
    end

    // zero_from[k] is set when nibbles k..7 of the active value are all
    // zero. It is built from the top nibble downward.
    always_comb begin
        zero_from    = 8'd0;
        zero_from[7] = (active_data[31:28] == 4'd0);
        for (int k = 6; k >= 0; k--) begin
            zero_from[k] = zero_from[k+1] && (active_data[4*k +: 4] == 4'd0);
        end
    end

    assign cur_nibble = active_data[{idx_q, 2'b00} +: 4];
    assign lz_blank   = LZ_SUPPRESS && (idx_q != 3'd0) && zero_from[idx_q];

    // Display outputs are decoded from the next state, so the registered
    // outputs already reflect the new state on the edge where it is entered.
    // This makes the outputs dark on the edge of an index change. A SHOW
    // next state implies no index change, so idx_q equals the digit being
    // shown, and the active buffer does not swap on that edge.
    always_comb begin
        an_d  = 8'hFF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (state_d == ST_SHOW) begin
            an_d[idx_q] = 1'b0;
            seg_d       = lz_blank ? 7'h7F : hex_to_seg(cur_nibble);
            dp_d        = ~active_dp[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an          <= 8'hFF;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= an_d;
            seg         <= seg_d;
            dp          <= dp_d;
            frame_start <= frame_edge;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
//
// tb_seg7_scan_driver
// -------------------
// This bench drives two instances of seg7_scan_driver from shared inputs:
// one with leading-zero suppression and one without.
//
// A reference model works in terms of "edges since the last index change"
// and whole buffers. On every clock edge it pushes the expected outputs
// into a scoreboard queue. A monitor pops one entry at every falling edge
// and compares it against both instances. Directed checks against literal
// values cover the scenarios that matter most.
//
module tb_seg7_scan_driver;

    localparam int B = 4;

    logic        clk;
    logic        rst_n;
    logic [2:0]  scan_idx;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic        load;

    logic        pending,   frame_start;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        pending_b, frame_start_b;
    logic [7:0]  an_b;
    logic [6:0]  seg_b;
    logic        dp_b;

    int asserts_evaluated = 0;
    int failures          = 0;

    seg7_scan_driver #(.BLANK_CYCLES(B), .LZ_SUPPRESS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .scan_idx(scan_idx), .data_in(data_in),
        .dp_in(dp_in), .load(load), .pending(pending),
        .frame_start(frame_start), .an(an), .seg(seg), .dp(dp)
    );

    seg7_scan_driver #(.BLANK_CYCLES(B), .LZ_SUPPRESS(1'b0)) dut_nolz (
        .clk(clk), .rst_n(rst_n), .scan_idx(scan_idx), .data_in(data_in),
        .dp_in(dp_in), .load(load), .pending(pending_b),
        .frame_start(frame_start_b), .an(an_b), .seg(seg_b), .dp(dp_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [6:0] hex_table [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Expected output vector: {pending, frame_start, an, seg, dp}.
    typedef struct packed {
        logic [17:0] main;
        logic [17:0] nolz;
    } exp_t;

    exp_t sb_q[$];
    bit   started = 0;

    // Reference model state.
    logic [2:0]  m_idx;
    logic [31:0] m_active, m_shadow;
    logic [7:0]  m_active_dp, m_shadow_dp;
    bit          m_pending;
    int          edge_n, last_change;

    function automatic logic [17:0] expOut(input bit lz, input bit lit,
                                           input logic [2:0] idx,
                                           input logic [31:0] d,
                                           input logic [7:0] p,
                                           input bit pend, input bit fs);
        logic [7:0]  a;
        logic [6:0]  s;
        logic        dv;
        logic [31:0] upper;
        a  = 8'hFF;
        s  = 7'h7F;
        dv = 1'b1;
        if (lit) begin
            a     = ~(8'd1 << idx);
            upper = d >> (4 * int'(idx));
            s     = (lz && idx != 3'd0 && upper == 32'd0) ? 7'h7F
                                                          : hex_table[upper[3:0]];
            dv    = ~p[idx];
        end
        return {pend, fs, a, s, dv};
    endfunction

    // Reference model: one scoreboard entry per clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idx       = 3'd0;
            m_active    = 32'd0;
            m_shadow    = 32'd0;
            m_active_dp = 8'd0;
            m_shadow_dp = 8'd0;
            m_pending   = 0;
            edge_n      = 0;
            last_change = 0;
            started     = 1;
            sb_q.delete();
            sb_q.push_back('{main: expOut(1, 0, 0, 0, 0, 0, 0),
                             nolz: expOut(0, 0, 0, 0, 0, 0, 0)});
        end else begin
            bit changed, boundary, lit;
            edge_n   = edge_n + 1;
            changed  = (scan_idx != m_idx);
            boundary = changed && m_idx == 3'd7 && scan_idx == 3'd0;
            if (boundary && m_pending) begin
                m_active    = m_shadow;
                m_active_dp = m_shadow_dp;
                m_pending   = 0;
            end else if (boundary) begin
                m_pending = 0;
            end
            if (load) begin
                m_shadow    = data_in;
                m_shadow_dp = dp_in;
                m_pending   = 1;
            end
            if (changed) begin
                last_change = edge_n;
                m_idx       = scan_idx;
            end
            lit = (edge_n - last_change) >= B;
            sb_q.push_back('{main: expOut(1, lit, m_idx, m_active, m_active_dp, m_pending, boundary),
                             nolz: expOut(0, lit, m_idx, m_active, m_active_dp, m_pending, boundary)});
        end
    end

    // Monitor: pop one expectation per cycle and compare both instances.
    always @(negedge clk) begin
        if (started) begin
            asserts_evaluated++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL sb_underflow: got empty queue, required one entry at %0t", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if ({pending, frame_start, an, seg, dp} !== e.main) begin
                    failures++;
                    $display("[TB] FAIL sb_lz {pend,fs,an,seg,dp} at %0t: got %05h required %05h",
                             $time, {pending, frame_start, an, seg, dp}, e.main);
                end
                asserts_evaluated++;
                if ({pending_b, frame_start_b, an_b, seg_b, dp_b} !== e.nolz) begin
                    failures++;
                    $display("[TB] FAIL sb_nolz {pend,fs,an,seg,dp} at %0t: got %05h required %05h",
                             $time, {pending_b, frame_start_b, an_b, seg_b, dp_b}, e.nolz);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        asserts_evaluated++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h required %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Called at a falling edge; leaves the inputs applied for 'cycles'
    // clocks. The load strobe lasts only the first clock.
    task automatic applyStimulus(input logic [2:0] idx, input logic ld,
                                 input logic [31:0] d, input logic [7:0] p,
                                 input int cycles);
        scan_idx = idx;
        load     = ld;
        data_in  = d;
        dp_in    = p;
        @(negedge clk);
        load = 1'b0;
        for (int i = 1; i < cycles; i++) @(negedge clk);
    endtask

    task automatic showDigit(input logic [2:0] idx);
        applyStimulus(idx, 1'b0, 32'd0, 8'd0, B + 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [6:0] lz_exp   [8] = '{7'b1000000, 7'b1000000, 7'b1111001, 7'h7F,
                                 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    logic [6:0] nolz_exp [8] = '{7'b1000000, 7'b1000000, 7'b1111001, 7'b1000000,
                                 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};

    initial begin
        logic [2:0] cur;
        rst_n    = 1'b1;
        scan_idx = 3'd0;
        data_in  = 32'd0;
        dp_in    = 8'd0;
        load     = 1'b0;
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // First light: four dark samples, then digit 0 shows 0.
        for (int i = 0; i < B; i++) begin
            @(negedge clk);
            checkOutput("reset_dark_an", {24'd0, an}, 32'hFF);
            checkOutput("reset_dark_seg", {25'd0, seg}, 32'h7F);
        end
        @(negedge clk);
        checkOutput("first_light_an", {24'd0, an}, 32'hFE);
        checkOutput("first_light_seg", {25'd0, seg}, 32'b1000000);

        // Blanking restart: 0->1, then 1->2 two cycles later.
        applyStimulus(3'd1, 1'b0, 32'd0, 8'd0, 2);
        scan_idx = 3'd2;
        for (int i = 0; i < B; i++) begin
            @(negedge clk);
            checkOutput("restart_dark_an", {24'd0, an}, 32'hFF);
        end
        @(negedge clk);
        checkOutput("restart_lit_an", {24'd0, an}, 32'hFB);

        // Double buffer: load mid-frame, swap at 7->0.
        applyStimulus(3'd3, 1'b1, 32'h0000_00A5, 8'h01, B + 4);
        checkOutput("db_pending_set", {31'd0, pending}, 32'd1);
        checkOutput("db_display_unchanged_seg", {25'd0, seg}, 32'h7F);
        for (int i = 4; i < 8; i++) applyStimulus(3'(i), 1'b0, 32'd0, 8'd0, B + 4);
        applyStimulus(3'd0, 1'b0, 32'd0, 8'd0, 1);
        checkOutput("db_frame_start", {31'd0, frame_start}, 32'd1);
        checkOutput("db_pending_clear", {31'd0, pending}, 32'd0);
        applyStimulus(3'd0, 1'b0, 32'd0, 8'd0, 1);
        checkOutput("db_frame_start_single", {31'd0, frame_start}, 32'd0);
        applyStimulus(3'd0, 1'b0, 32'd0, 8'd0, B - 1);
        checkOutput("db_digit0_an", {24'd0, an}, 32'hFE);
        checkOutput("db_digit0_seg", {25'd0, seg}, 32'b0010010);
        checkOutput("db_digit0_dp", {31'd0, dp}, 32'd0);
        showDigit(3'd1);
        checkOutput("db_digit1_seg", {25'd0, seg}, 32'b0001000);
        checkOutput("db_digit1_dp", {31'd0, dp}, 32'd1);
        for (int i = 2; i < 8; i++) begin
            showDigit(3'(i));
            checkOutput("db_lz_seg", {25'd0, seg}, 32'h7F);
            checkOutput("db_nolz_seg", {25'd0, seg_b}, 32'b1000000);
        end

        // Leading zeros with active = 0x00000100.
        applyStimulus(3'd0, 1'b1, 32'h0000_0100, 8'h00, B + 1);
        for (int i = 1; i < 8; i++) showDigit(3'(i));
        for (int i = 0; i < 8; i++) begin
            showDigit(3'(i));
            checkOutput("lz_an", {24'd0, an}, {24'd0, ~(8'd1 << i)});
            checkOutput("lz_seg", {25'd0, seg}, {25'd0, lz_exp[i]});
            checkOutput("nolz_seg", {25'd0, seg_b}, {25'd0, nolz_exp[i]});
        end

        // Load collision at the boundary.
        for (int i = 0; i < 8; i++) begin
            if (i == 2) applyStimulus(3'd2, 1'b1, 32'h1111_1111, 8'h00, B + 1);
            else        showDigit(3'(i));
        end
        applyStimulus(3'd0, 1'b1, 32'h2222_2222, 8'h00, B + 1);
        checkOutput("coll_pending_kept", {31'd0, pending}, 32'd1);
        checkOutput("coll_ones_seg", {25'd0, seg}, 32'b1111001);
        for (int i = 1; i < 8; i++) showDigit(3'(i));
        showDigit(3'd0);
        checkOutput("coll_twos_seg", {25'd0, seg}, 32'b0100100);
        checkOutput("coll_pending_clear", {31'd0, pending}, 32'd0);

        // Asynchronous reset while a digit is shown and data is pending.
        applyStimulus(3'd1, 1'b1, 32'h1234_5678, 8'hFF, B + 1);
        checkOutput("ar_pre_pending", {31'd0, pending}, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("ar_an", {24'd0, an}, 32'hFF);
        checkOutput("ar_seg", {25'd0, seg}, 32'h7F);
        checkOutput("ar_dp", {31'd0, dp}, 32'd1);
        checkOutput("ar_pending", {31'd0, pending}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Randomized scanning with loads; the scoreboard does the checking.
        cur = scan_idx;
        for (int n = 0; n < 250; n++) begin
            logic [2:0]  nxt;
            logic [31:0] d;
            int          hold;
            int          sh;
            nxt  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : cur + 3'd1;
            hold = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3)
                                               : $urandom_range(B + 1, B + 6);
            sh   = $urandom_range(0, 8);
            d    = (sh == 8) ? 32'd0 : ($urandom >> (4 * sh));
            applyStimulus(nxt, 1'($urandom_range(0, 3) == 0), d, 8'($urandom), 1);
            for (int c = 1; c < hold; c++) begin
                sh = $urandom_range(0, 8);
                d  = (sh == 8) ? 32'd0 : ($urandom >> (4 * sh));
                applyStimulus(nxt, 1'($urandom_range(0, 5) == 0), d, 8'($urandom), 1);
            end
            cur = nxt;
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts_evaluated, failures);
        $finish;
    end

endmodule
